// File: rtl/sm4_pkg.sv
// Shared SM4 types, FSM encoding and the S-box table used by the masked
// substitution datapath.
package sm4_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam byte_t SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  function automatic byte_t sm4_sbox(input byte_t a);
    return SBOX[a];
  endfunction

endpackage

// File: rtl/sm4_sbox_byte.sv
// Combinational SM4 S-box for a single byte; one instance per lane.
module sm4_sbox_byte
  import sm4_pkg::*;
(
  input  byte_t in_i,
  output byte_t out_o
);

  assign out_o = sm4_sbox(in_i);

endmodule

// File: rtl/sm4_masked_subword.sv
// Masked SM4 substitution over an NBYTES word, LANES bytes per clock.
// Build option SM4_SUB_REFRESH_EN adds the rnd port and re-masks the output with it.
module sm4_masked_subword
  import sm4_pkg::*;
#(
  parameter int NBYTES = 4,
  parameter int LANES  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [8*NBYTES-1:0] x,
  input  logic [8*NBYTES-1:0] m,
`ifdef SM4_SUB_REFRESH_EN
  input  logic [8*NBYTES-1:0] rnd,
`endif
  output logic                busy,
  output logic                finish,
  output logic [8*NBYTES-1:0] x_out,
  output logic [8*NBYTES-1:0] m_out
);

  localparam int W          = 8 * NBYTES;
  localparam int LANES_SAFE = (LANES < 1) ? 1 : LANES;
  localparam int C          = NBYTES / LANES_SAFE;
  localparam int CW         = $clog2(C) + 1;
  localparam logic [CW-1:0] GRP_LAST = CW'(C - 1);

  if (NBYTES < 1 || LANES < 1 || LANES > NBYTES || (NBYTES % LANES_SAFE) != 0) begin : g_bad_cfg
    $error("sm4_masked_subword: LANES must be in 1..NBYTES and divide NBYTES");
  end

  state_e          state_q, state_d;
  logic [CW-1:0]   grp_q, grp_d;
  logic            capture, advance;

  // Operand registers shift down one lane group per RUN edge, so the lanes
  // always read their bytes from the bottom of the word.
  logic [W-1:0]    x_q, x_d, m_q, m_d;
  logic [W-1:0]    x_out_q, x_out_d, m_out_q, m_out_d;
  logic [8*LANES-1:0] lane_x, lane_m;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grp_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      grp_q   <= grp_d;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    state_d = state_q;
    grp_d   = grp_q;
    capture = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          grp_d   = '0;
          capture = 1'b1;
        end
      end
      ST_RUN: begin
        advance = 1'b1;
        if (grp_q == GRP_LAST) begin
          state_d = ST_DONE;
          grp_d   = '0;
        end else begin
          grp_d = grp_q + CW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy   = (state_q != ST_IDLE);
  assign finish = (state_q == ST_DONE);

  // ------------------------------------------------------ operand capture
  always_comb begin
    x_d = x_q;
    m_d = m_q;
    if (capture) begin
      x_d = x;
      m_d = m;
    end else if (advance) begin
      x_d = x_q >> (8 * LANES);
      m_d = m_q >> (8 * LANES);
    end
  end

`ifdef SM4_SUB_REFRESH_EN
  logic [W-1:0] r_q, r_d;

  always_comb begin
    r_d = r_q;
    if (capture) begin
      r_d = rnd;
    end else if (advance) begin
      r_d = r_q >> (8 * LANES);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end
`endif

  // ---------------------------------------------------------------- lanes
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    byte_t s_in, s_out, o_mask;

    assign s_in = x_q[8*l +: 8] ^ m_q[8*l +: 8];
`ifdef SM4_SUB_REFRESH_EN
    assign o_mask = m_q[8*l +: 8] ^ r_q[8*l +: 8];
`else
    assign o_mask = m_q[8*l +: 8];
`endif

    sm4_sbox_byte u_sbox (
      .in_i  (s_in),
      .out_o (s_out)
    );

    assign lane_x[8*l +: 8] = s_out ^ o_mask;
    assign lane_m[8*l +: 8] = o_mask;
  end

  // Byte b is written by lane b%LANES on the edge that processes group b/LANES.
  for (genvar b = 0; b < NBYTES; b++) begin : g_byte
    localparam int L = b % LANES_SAFE;
    logic wr;

    assign wr = advance && (grp_q == CW'(b / LANES_SAFE));
    assign x_out_d[8*b +: 8] = wr ? lane_x[8*L +: 8] : x_out_q[8*b +: 8];
    assign m_out_d[8*b +: 8] = wr ? lane_m[8*L +: 8] : m_out_q[8*b +: 8];
  end

  // ------------------------------------------------------ data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are reset as well; captured operands and the last result must not survive a reset.
      x_q     <= '0;
      m_q     <= '0;
      x_out_q <= '0;
      m_out_q <= '0;
    end else begin
      x_q     <= x_d;
      m_q     <= m_d;
      x_out_q <= x_out_d;
      m_out_q <= m_out_d;
    end
  end

  assign x_out = x_out_q;
  assign m_out = m_out_q;

endmodule

// File: tb/tb_sm4_masked_subword.sv
// Self-checking bench: three instances (LANES 1, 2, 4) share stimulus and are
// checked every cycle against a transaction-level latency/result model.
module tb_sm4_masked_subword;

  localparam int ND = 3;
  localparam int RUN_CYC [ND] = '{4, 2, 1};
`ifdef SM4_SUB_REFRESH_EN
  localparam bit REFRESH = 1'b1;
`else
  localparam bit REFRESH = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] x     = '0;
  logic [31:0] m     = '0;
  logic [31:0] rnd   = '0;

  logic        busy_a [ND];
  logic        fin_a  [ND];
  logic [31:0] xo_a   [ND];
  logic [31:0] mo_a   [ND];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int          left    [ND] = '{default: 0};
  int          acc_cyc [ND] = '{default: 0};
  logic [31:0] ex      [ND] = '{default: '0};
  logic [31:0] em      [ND] = '{default: '0};
  logic [31:0] hold_x  [ND] = '{default: '0};
  logic [31:0] hold_m  [ND] = '{default: '0};

  logic [7:0] sb [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  always #5 clk = ~clk;

  sm4_masked_subword #(.NBYTES(4), .LANES(1)) u_dut_l1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .x      (x),
    .m      (m),
`ifdef SM4_SUB_REFRESH_EN
    .rnd    (rnd),
`endif
    .busy   (busy_a[0]),
    .finish (fin_a[0]),
    .x_out  (xo_a[0]),
    .m_out  (mo_a[0])
  );

  sm4_masked_subword #(.NBYTES(4), .LANES(2)) u_dut_l2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .x      (x),
    .m      (m),
`ifdef SM4_SUB_REFRESH_EN
    .rnd    (rnd),
`endif
    .busy   (busy_a[1]),
    .finish (fin_a[1]),
    .x_out  (xo_a[1]),
    .m_out  (mo_a[1])
  );

  sm4_masked_subword #(.NBYTES(4), .LANES(4)) u_dut_l4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .x      (x),
    .m      (m),
`ifdef SM4_SUB_REFRESH_EN
    .rnd    (rnd),
`endif
    .busy   (busy_a[2]),
    .finish (fin_a[2]),
    .x_out  (xo_a[2]),
    .m_out  (mo_a[2])
  );

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sb[v[8*i +: 8]];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Model: an accepted request completes C+1 edges later and the outputs then
  // hold the whole substituted word; the next request is accepted one cycle after.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < ND; d++) begin
        left[d]   = 0;
        hold_x[d] = '0;
        hold_m[d] = '0;
      end
    end else begin
      cyc++;
      for (int d = 0; d < ND; d++) begin
        if (left[d] == 0) begin
          if (start) begin
            em[d]      = m ^ (REFRESH ? rnd : 32'h0);
            ex[d]      = sub_word(x ^ m) ^ em[d];
            left[d]    = RUN_CYC[d] + 1;
            acc_cyc[d] = cyc;
          end
        end else begin
          if (left[d] == 1) begin
            hold_x[d] = ex[d];
            hold_m[d] = em[d];
          end
          left[d]--;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      check($sformatf("busy[%0d]", d), 32'(busy_a[d]), 32'(left[d] != 0));
      check($sformatf("finish[%0d]", d), 32'(fin_a[d]), 32'(left[d] == 1));
      if (left[d] == 1) begin
        check($sformatf("x_out[%0d]", d), xo_a[d], ex[d]);
        check($sformatf("m_out[%0d]", d), mo_a[d], em[d]);
        check($sformatf("unmask[%0d]", d), xo_a[d] ^ mo_a[d], sub_word(ex[d] ^ em[d]) ^ sub_word(ex[d] ^ em[d]) ^ (ex[d] ^ em[d]));
      end else if (left[d] == 0) begin
        check($sformatf("hold_x[%0d]", d), xo_a[d], hold_x[d]);
        check($sformatf("hold_m[%0d]", d), mo_a[d], hold_m[d]);
      end
    end
  end

  task automatic pulse(input logic [31:0] xv, input logic [31:0] mv, input logic [31:0] rv);
    @(negedge clk);
    x = xv; m = mv; rnd = rv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_only(input int d, input string tag, output int at);
    int n = 0;
    while (fin_a[d] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_seen"}, 32'(fin_a[d]), 32'd1);
    at = cyc;
  endtask

  task automatic wait_fin(input int d, input int lat, input logic [31:0] xe,
                          input logic [31:0] me, input string tag);
    int at;
    wait_only(d, tag, at);
    check({tag, "_lat"}, 32'(at - acc_cyc[d]), 32'(lat));
    check({tag, "_x"}, xo_a[d], xe);
    check({tag, "_m"}, mo_a[d], me);
  endtask

  initial begin
    int t1, t2;
    repeat (2) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("rst_busy[%0d]", d), 32'(busy_a[d]), 32'd0);
      check($sformatf("rst_x_out[%0d]", d), xo_a[d], 32'h0);
    end
    rst_n = 1'b1;

    // Test 1: all-zero word, zero mask
    pulse(32'h0000_0000, 32'h0000_0000, 32'h0);
    wait_fin(0, 4, 32'hD6D6_D6D6, 32'h0, "t1");

    // Test 2: x^m == 0 with a non-zero mask
    pulse(32'h0101_0101, 32'h0101_0101, 32'h0);
    wait_fin(0, 4, 32'hD7D7_D7D7, 32'h0101_0101, "t2");

    // Test 5: reset in the second RUN cycle clears everything at once
    pulse(32'hFF10_0100, 32'h0, 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("t5_busy[%0d]", d), 32'(busy_a[d]), 32'd0);
      check($sformatf("t5_finish[%0d]", d), 32'(fin_a[d]), 32'd0);
      check($sformatf("t5_x_out[%0d]", d), xo_a[d], 32'h0);
      check($sformatf("t5_m_out[%0d]", d), mo_a[d], 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulse(32'hFF10_0100, 32'h0, 32'h0);
    wait_fin(0, 4, 32'h482B_90D6, 32'h0, "t5_after");

    // Test 3: the wider instances finish after 1 and 2 RUN cycles
    pulse(32'hFF10_0100, 32'h0, 32'h0);
    wait_fin(2, 1, 32'h482B_90D6, 32'h0, "t3_l4");
    wait_fin(1, 2, 32'h482B_90D6, 32'h0, "t3_l2");
    wait_fin(0, 4, 32'h482B_90D6, 32'h0, "t3_l1");

    // Test 4: start held high gives a single-cycle finish every C+2 cycles
    @(negedge clk);
    x = 32'h1234_5678; m = 32'h0F0F_0F0F; rnd = 32'h0; start = 1'b1;
    wait_only(0, "t4_a", t1);
    @(negedge clk);
    check("t4_single", 32'(fin_a[0]), 32'd0);
    wait_only(0, "t4_b", t2);
    check("t4_period", 32'(t2 - t1), 32'd6);
    start = 1'b0;
    repeat (8) @(negedge clk);

`ifdef SM4_SUB_REFRESH_EN
    // Test 6: output mask refreshed from rnd
    pulse(32'h0, 32'h0, 32'hA5A5_A5A5);
    wait_fin(0, 4, 32'h7373_7373, 32'hA5A5_A5A5, "t6");
`endif

    // Random traffic, mostly back-to-back, checked by the model each cycle
    for (int i = 0; i < 7000; i++) begin
      @(negedge clk);
      x     = $urandom;
      m     = $urandom;
      rnd   = $urandom;
      start = ($urandom_range(0, 7) != 0);
    end
    start = 1'b0;
    repeat (8) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
